// File: rtl/demux4_buf_pkg.sv
// demux4_buf shared definitions: channel count, select width
// and channel index names. Optional feature macro: DEMUX4_BYPASS_EN.
package demux4_buf_pkg;

  localparam int DEMUX_CH    = 4;
  localparam int DEMUX_SEL_W = 2;

  typedef logic [DEMUX_SEL_W-1:0] ch_idx_t;

  localparam ch_idx_t CH_DM    = 2'd0;
  localparam ch_idx_t CH_TIMER = 2'd1;
  localparam ch_idx_t CH_IO    = 2'd2;
  localparam ch_idx_t CH_SPARE = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single channel.
// Optional same-cycle pass-through when DEMUX4_BYPASS_EN is defined.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] req_data,
  input  logic             ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] hold;
  logic             byp;
  logic             load;

`ifdef DEMUX4_BYPASS_EN
  assign byp = req & ~full & ready;
`else
  assign byp = 1'b0;
`endif

  assign load  = req & ~byp;
  assign valid = full | byp;
  assign data  = byp ? req_data : hold;

  // load wins over drain so a reload keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      hold <= '0;
    end else begin
      full <= load | (full & ~ready);
      if (load) hold <= req_data;
    end
  end

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: buffered 1-to-4 valid/ready demultiplexer.
// Optional combinational bypass via DEMUX4_BYPASS_EN.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  ch_idx_t             in_sel,
  input  logic [WIDTH-1:0]    in_data,
  output logic [DEMUX_CH-1:0] out_valid,
  input  logic [DEMUX_CH-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data0,
  output logic [WIDTH-1:0]    out_data1,
  output logic [WIDTH-1:0]    out_data2,
  output logic [WIDTH-1:0]    out_data3,
  output logic                busy
);

  logic [DEMUX_CH-1:0] full;
  logic [DEMUX_CH-1:0] req;
  logic [WIDTH-1:0]    data [DEMUX_CH];
  logic                acc;

  assign in_ready = ~full[in_sel] | out_ready[in_sel];
  assign acc      = in_valid & in_ready;
  assign busy     = |full;

  // decode the accepted beat onto its destination slot
  always_comb begin
    req = '0;
    unique case (in_sel)
      CH_DM:    req[0] = acc;
      CH_TIMER: req[1] = acc;
      CH_IO:    req[2] = acc;
      CH_SPARE: req[3] = acc;
    endcase
  end

  for (genvar k = 0; k < DEMUX_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[k]),
      .req_data(in_data),
      .ready   (out_ready[k]),
      .full    (full[k]),
      .valid   (out_valid[k]),
      .data    (data[k])
    );
  end

  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: directed + random checks of demux4_buf
// against per-channel queue model.
module tb_demux4_buf;
  import demux4_buf_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  ch_idx_t      in_sel = '0;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_ready = '0;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic         busy;

  int ncmp = 0;
  int nerr = 0;
  int mpush = 0;
  int dpop = 0;

  logic [W-1:0] q [4][$];

  demux4_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(d0), .out_data1(d1),
    .out_data2(d2), .out_data3(d3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dsel(int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic byp(int k);
`ifdef DEMUX4_BYPASS_EN
    return in_valid && (int'(in_sel) == k) &&
           q[k].size() == 0 && out_ready[k];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_rdy();
    return q[in_sel].size() == 0 || out_ready[in_sel];
  endfunction

  // model: capacity-1 queue per channel
  always @(posedge clk) begin
    if (rst_n) begin
      int pre [4];
      logic bp [4];
      logic acc;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) dpop++;
        pre[k] = q[k].size();
        bp[k] = byp(k);
      end
      acc = in_valid && m_rdy();
      if (acc) begin
        q[in_sel].push_back(in_data);
        mpush++;
      end
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && (pre[k] > 0 || bp[k]))
          void'(q[k].pop_front());
    end
  end

  always @(negedge rst_n)
    for (int k = 0; k < 4; k++) q[k].delete();

  // compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] ev;
      logic any;
      any = 1'b0;
      for (int k = 0; k < 4; k++) begin
        ev[k] = q[k].size() > 0 || byp(k);
        any = any | (q[k].size() > 0);
      end
      chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy()});
      chk("busy", {31'd0, busy}, {31'd0, any});
      for (int k = 0; k < 4; k++)
        if (ev[k])
          chk($sformatf("data%0d", k), dsel(k),
              q[k].size() > 0 ? q[k][0] : in_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input ch_idx_t s,
                       input logic [W-1:0] d,
                       input logic [3:0] r);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
  endtask

  initial begin
    int sent, budget, p0, dp0;
    ch_idx_t cs;
    logic [W-1:0] cd;
    logic a;

    repeat (2) cyc();
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_d0", d0, 32'd0);
    chk("rst_d3", d3, 32'd0);
    rst_n = 1'b1;
    cyc();

    // single beat to ch2
    drive(1'b1, CH_IO, 32'hDEADBEEF, 4'b0000);
    #1;
    chk("single_rdy", {31'd0, in_ready}, 32'd1);
    cyc();
    drive(1'b0, CH_DM, 32'd0, 4'b0000);
    #1;
    chk("single_valid", {28'd0, out_valid}, 32'h4);
    chk("single_d2", d2, 32'hDEADBEEF);
    out_ready = 4'b0100;
    cyc();
    out_ready = 4'b0000;
    #1;
    chk("single_drained", {28'd0, out_valid}, 32'd0);

    // backpressure isolation on ch1
    drive(1'b1, CH_TIMER, 32'hA1, 4'b1101);
    cyc();
    drive(1'b1, CH_TIMER, 32'hB1, 4'b1101);
    #1;
    chk("bp_stall", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("bp_hold", d1, 32'hA1);
    drive(1'b1, CH_SPARE, 32'hC3, 4'b1101);
    #1;
    chk("bp_ch3_rdy", {31'd0, in_ready}, 32'd1);
    cyc();
    drive(1'b1, CH_TIMER, 32'hB1, 4'b1111);
    #1;
    chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_still_a", d1, 32'hA1);
    cyc();
    chk("bp_next_b", d1, 32'hB1);
    drive(1'b0, CH_DM, 32'd0, 4'b1111);
    cyc();

    // full throughput on ch0
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CH_DM, 32'h10 + i, 4'b1111);
      #1;
      chk("tp_rdy", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("tp_d0", d0, 32'h10 + i);
    end
    drive(1'b0, CH_DM, 32'd0, 4'b1111);
    cyc();

    // drain + reload on ch3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CH_SPARE, 32'hA0 + i, 4'b1000);
      cyc();
      chk("rl_valid", {28'd0, out_valid}, 32'h8);
      chk("rl_d3", d3, 32'hA0 + i);
    end
    drive(1'b0, CH_DM, 32'd0, 4'b1111);
    cyc();

    // asynchronous reset mid-operation
    drive(1'b1, CH_DM, 32'h11, 4'b0000);
    cyc();
    drive(1'b1, CH_IO, 32'h22, 4'b0000);
    cyc();
    drive(1'b0, CH_DM, 32'd0, 4'b0000);
    #1;
    chk("pre_rst_valid", {28'd0, out_valid}, 32'h5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {28'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_d0", d0, 32'd0);
    chk("arst_d2", d2, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // random traffic, beats held until accepted
    p0 = mpush;
    dp0 = dpop;
    sent = 0;
    budget = 0;
    cs = ch_idx_t'($urandom_range(3));
    cd = 32'h4000_0000;
    while (sent < 2000 && budget < 40000) begin
      drive(1'b1, cs, cd, 4'($urandom_range(15)));
      #1;
      a = m_rdy();
      cyc();
      budget++;
      if (a) begin
        sent++;
        cs = ch_idx_t'($urandom_range(3));
        cd = 32'h4000_0000 + sent;
      end
    end
    if (sent < 2000) begin
      ncmp++;
      nerr++;
      $display("FAIL rand_budget: sent %0d want 2000", sent);
    end
    drive(1'b0, CH_DM, 32'd0, 4'b1111);
    repeat (4) cyc();
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_count", dpop - dp0, mpush - p0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
